riscv_ic_core: RTL and testbench
================================

// Module: riscv_ic_core
// PURPOSE
//  Single-cycle RV32I hart for the SoC top; it fetches and executes one instruction per clk.
//  Instruction fetch uses the ibus, and loads/stores use the dbus. Both buses are combinational-read
//  (the read data is valid in the same cycle as the address) and write on the clk edge.
//  Interrupt lines come from peripherals (bit0 = timer). A JTAG halt request freezes the hart.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC loaded on reset
//  INT_WIDTH  8              width of I_int; bit0 = machine timer interrupt
// PORTS
//  clk             in   1   system clock, all state on rising edge
//  rst             in   1   reset, asynchronous, active-high
//  O_ibus_req      out  1   fetch request; 1 whenever not in reset and not halted
//  O_ibus_we       out  1   constant 0
//  O_ibus_addr     out  32  PC, word-aligned
//  O_ibus_data     out  32  constant 0
//  O_ibus_mask     out  4   constant 4'b1111
//  I_ibus_data     in   32  instruction word at O_ibus_addr, same cycle
//  O_dbus_req      out  1   load/store active this cycle
//  O_dbus_we       out  1   1 = store
//  O_dbus_addr     out  32  effective address with [1:0] forced to 0
//  O_dbus_data     out  32  store data, shifted to its byte lanes
//  O_dbus_mask     out  4   byte enables (bit n = byte n)
//  I_dbus_data     in   32  aligned word read, same cycle
//  I_int           in   INT_WIDTH  level interrupt requests
//  I_jtag_haltreq  in   1   1 = stall the hart
// BEHAVIOUR
//  - Reset (async, while rst=1):
//    - PC=RESET_PC; x1..x31 cleared.
//    - Outputs O_ibus_req=0 and O_dbus_req=0.
//  - Execution:
//    - Each cycle decodes I_ibus_data and executes it completely.
//    - On the clk edge the core writes rd (never x0) and updates the PC (PC+4, branch or jump target).
//  - ISA: LUI AUIPC JAL JALR BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM, OP.
//    - All arithmetic is mod 2^32. Shifts use the low 5 bits of the shift amount. SRA/SRAI sign-fill.
//    - JALR target: (rs1+imm) & ~1. Any unrecognised opcode executes as a NOP (PC+4).
//  - Loads:
//    - Byte select is addr[1:0]. LB/LBU read byte addr[1:0]; LH/LHU read half addr[1].
//    - LB/LH sign-extend; LBU/LHU zero-extend.
//  - Stores:
//    - SB: mask=1<<addr[1:0], data=rs2[7:0] replicated x4.
//    - SH: mask=3<<{addr[1],1'b0}, data={2{rs2[15:0]}}.
//    - SW: mask=4'hF.
//  - Misaligned halfword/word: the low address bits are ignored (lane chosen as above); no trap.
//  - O_dbus_req=0 and O_dbus_mask=0 when the instruction is not a load or store.
//  - Halt: while I_jtag_haltreq=1, the core holds the PC and writes no registers.
//    - Outputs: O_dbus_req=0, O_ibus_req=0.
//    - Execution resumes at the held PC the cycle after the halt request drops.
//  - Reset mid-execution aborts the instruction: no register or memory write.
// CONFIGURATION
//  RISCV_IC_IRQ_EN defined:
//  - CSRs implemented: mstatus (MIE bit3, MPIE bit7), mie, mip (read-only = I_int), mtvec, mepc, mcause.
//    - CSRRW/S/C and their immediate forms are supported. All CSRs reset to 0.
//  - Interrupt taken before executing the instruction at PC when mstatus.MIE && |(I_int & mie).
//    - mepc=PC; mcause=32'h8000_0000|lowest pending index.
//    - MPIE=MIE, MIE=0, PC=mtvec&~3. No instruction retires that cycle.
//  - ECALL: mepc=PC, mcause=11, PC=mtvec.
//  - MRET: PC=mepc, MIE=MPIE, MPIE=1.
//  - Halt has priority over interrupt.
//  Not defined: SYSTEM opcodes execute as NOPs, I_int is ignored, and no CSR state exists.
// TESTING
//  1 reset release: first O_ibus_addr=0x8000_0000, next 0x8000_0004 (NOP stream).
//  2 addi x1,x0,-1; srli x2,x1,28; srai x3,x1,4 -> x2=0x0000000F, x3=0xFFFFFFFF;
//    beq x0,x0,+8 skips next instruction.
//  3 x5=0x8000_1003, x6=0x12345678, sb x6,0(x5)
//    -> dbus addr=0x8000_1000, mask=4'b1000, data=0x78787878, we=1.
//  4 I_dbus_data=0x80FF7F01, lb at addr..1 -> 0x0000007F; lh at addr..2 -> 0xFFFF80FF;
//    lbu at addr..3 -> 0x00000080.
//  5 I_jtag_haltreq=1 for 3 cycles mid-program:
//    -> PC frozen, ibus_req=dbus_req=0, no register change; resumes at same PC.
//  6 (IRQ_EN) mtvec=0x8000_0100, mie=1, MIE=1, I_int[0]=1
//    -> next PC=0x8000_0100, mcause=0x8000_0000; mret returns to mepc.

Source files
------------

// File: rtl/riscv_ic_core.sv
// riscv_ic_core: single-cycle RV32I hart. One instruction is fetched, decoded and executed
// every clk; rd and the PC are committed on the rising edge.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   O_ibus_*            fetch bus (combinational read at O_ibus_addr = PC)
//   I_ibus_data         instruction word for the current PC
//   O_dbus_*            load/store bus (combinational read, write on clk edge)
//   I_dbus_data         aligned read word for O_dbus_addr
//   I_int               level interrupt requests (bit0 = machine timer)
//   I_jtag_haltreq      freezes PC and register state while high
//
// Configuration
//   RISCV_IC_IRQ_EN     adds mstatus/mie/mip/mtvec/mepc/mcause, CSRRx, ECALL, MRET and
//                       interrupt entry. Undefined: SYSTEM opcodes are NOPs and I_int is ignored.
module riscv_ic_core #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned INT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 O_ibus_req,
  output logic                 O_ibus_we,
  output logic [31:0]          O_ibus_addr,
  output logic [31:0]          O_ibus_data,
  output logic [3:0]           O_ibus_mask,
  input  logic [31:0]          I_ibus_data,
  output logic                 O_dbus_req,
  output logic                 O_dbus_we,
  output logic [31:0]          O_dbus_addr,
  output logic [31:0]          O_dbus_data,
  output logic [3:0]           O_dbus_mask,
  input  logic [31:0]          I_dbus_data,
  input  logic [INT_WIDTH-1:0] I_int,
  input  logic                 I_jtag_haltreq
);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
`ifdef RISCV_IC_IRQ_EN
  localparam logic [6:0] OP_SYSTEM = 7'h73;
`endif

  logic [31:0] pc_q, pc_next;
  logic [31:0] regs_q [32];

  // Instruction fields
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  assign instr  = I_ibus_data;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'h000};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs_q[rs2];

  // ALU shared by OP and OP-IMM; instr[30] selects SUB (OP only) and SRA/SRAI.
  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;

  always_comb begin
    alu_b = (opcode == OP_REG) ? rs2_val : imm_i;
    shamt = alu_b[4:0];
    case (f3)
      3'b000:  alu_res = (opcode == OP_REG && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_res = rs1_val << shamt;
      3'b010:  alu_res = {31'h0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_res = {31'h0, rs1_val < alu_b};
      3'b100:  alu_res = rs1_val ^ alu_b;
      3'b101:  alu_res = instr[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'b110:  alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  logic br_taken;

  always_comb begin
    case (f3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = $signed(rs1_val) < $signed(rs2_val);
      3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  br_taken = rs1_val < rs2_val;
      3'b111:  br_taken = rs1_val >= rs2_val;
      default: br_taken = 1'b0;
    endcase
  end

  // Load/store address and lane extraction
  logic [31:0] ls_addr;
  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ls_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign lane    = ls_addr[1:0];
  assign ld_byte = I_dbus_data[{lane, 3'b000} +: 8];
  assign ld_half = lane[1] ? I_dbus_data[31:16] : I_dbus_data[15:0];

  logic        rd_we;
  logic [31:0] rd_val;
  logic        ls_req, ls_we;
  logic [3:0]  ls_mask;
  logic [31:0] ls_wdata;
  logic        irq_take;

`ifdef RISCV_IC_IRQ_EN
  logic        mstatus_mie_q, mstatus_mpie_q;
  logic [31:0] mie_q, mtvec_q, mepc_q, mcause_q;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata, csr_src, csr_wdata;
  logic        csr_we, ecall, mret;
  logic [4:0]  irq_idx;
  logic [INT_WIDTH-1:0] irq_vec;

  assign csr_addr = instr[31:20];
  assign csr_src  = f3[2] ? {27'h0, rs1} : rs1_val;
  assign irq_vec  = I_int & mie_q[INT_WIDTH-1:0];
  assign irq_take = mstatus_mie_q && (|irq_vec) && !I_jtag_haltreq;

  always_comb begin
    irq_idx = 5'd0;
    for (int i = INT_WIDTH - 1; i >= 0; i--) begin
      if (irq_vec[i]) irq_idx = 5'(i);
    end
  end

  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
      12'h304: csr_rdata = mie_q;
      12'h305: csr_rdata = mtvec_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h344: csr_rdata = 32'(I_int);
      default: csr_rdata = 32'h0;
    endcase
    case (f3[1:0])
      2'b01:   csr_wdata = csr_src;
      2'b10:   csr_wdata = csr_rdata | csr_src;
      2'b11:   csr_wdata = csr_rdata & ~csr_src;
      default: csr_wdata = csr_rdata;
    endcase
  end
`else
  logic unused_int;
  assign unused_int = ^I_int;
  assign irq_take   = 1'b0;
`endif

  always_comb begin
    pc_next  = pc_q + 32'd4;
    rd_we    = 1'b0;
    rd_val   = 32'h0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_mask  = 4'h0;
    ls_wdata = 32'h0;
`ifdef RISCV_IC_IRQ_EN
    csr_we   = 1'b0;
    ecall    = 1'b0;
    mret     = 1'b0;
`endif
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_val = pc_q + imm_u; end
      OP_JAL: begin
        rd_we   = 1'b1;
        rd_val  = pc_q + 32'd4;
        pc_next = pc_q + imm_j;
      end
      OP_JALR: begin
        if (f3 == 3'b000) begin
          rd_we   = 1'b1;
          rd_val  = pc_q + 32'd4;
          pc_next = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: if (br_taken) pc_next = pc_q + imm_b;
      OP_LOAD: begin
        ls_mask = 4'hF;
        case (f3)
          3'b000:  begin ls_req = 1'b1; rd_val = {{24{ld_byte[7]}}, ld_byte}; end
          3'b001:  begin ls_req = 1'b1; rd_val = {{16{ld_half[15]}}, ld_half}; end
          3'b010:  begin ls_req = 1'b1; rd_val = I_dbus_data; end
          3'b100:  begin ls_req = 1'b1; rd_val = {24'h0, ld_byte}; end
          3'b101:  begin ls_req = 1'b1; rd_val = {16'h0, ld_half}; end
          default: ls_req = 1'b0;
        endcase
        rd_we = ls_req;
      end
      OP_STORE: begin
        ls_we = 1'b1;
        case (f3)
          3'b000:  begin ls_req = 1'b1; ls_mask = 4'b0001 << lane;
                         ls_wdata = {4{rs2_val[7:0]}}; end
          3'b001:  begin ls_req = 1'b1; ls_mask = 4'b0011 << {lane[1], 1'b0};
                         ls_wdata = {2{rs2_val[15:0]}}; end
          3'b010:  begin ls_req = 1'b1; ls_mask = 4'hF; ls_wdata = rs2_val; end
          default: ls_req = 1'b0;
        endcase
      end
      OP_IMM, OP_REG: begin rd_we = 1'b1; rd_val = alu_res; end
`ifdef RISCV_IC_IRQ_EN
      OP_SYSTEM: begin
        if (f3[1:0] != 2'b00) begin
          rd_we  = 1'b1;
          rd_val = csr_rdata;
          // Set/clear with a zero source must not write (keeps read-only probes side-effect free)
          csr_we = (f3[1:0] == 2'b01) || (rs1 != 5'd0);
        end else if (f3 == 3'b000 && instr[31:20] == 12'h000) begin
          ecall   = 1'b1;
          pc_next = mtvec_q;
        end else if (f3 == 3'b000 && instr[31:20] == 12'h302) begin
          mret    = 1'b1;
          pc_next = mepc_q;
        end
      end
`endif
      default: ;
    endcase
    // Interrupt entry replaces the fetched instruction entirely
    if (irq_take) begin
      rd_we   = 1'b0;
      ls_req  = 1'b0;
`ifdef RISCV_IC_IRQ_EN
      csr_we  = 1'b0;
      ecall   = 1'b0;
      mret    = 1'b0;
      pc_next = {mtvec_q[31:2], 2'b00};
`endif
    end
  end

  logic active;
  assign active = !rst && !I_jtag_haltreq;

  assign O_ibus_req  = active;
  assign O_ibus_we   = 1'b0;
  assign O_ibus_addr = {pc_q[31:2], 2'b00};
  assign O_ibus_data = 32'h0;
  assign O_ibus_mask = 4'hF;

  assign O_dbus_req  = active && ls_req;
  assign O_dbus_we   = O_dbus_req && ls_we;
  assign O_dbus_addr = {ls_addr[31:2], 2'b00};
  assign O_dbus_data = ls_wdata;
  assign O_dbus_mask = O_dbus_req ? ls_mask : 4'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else if (!I_jtag_haltreq) begin
      pc_q <= pc_next;
      if (rd_we && rd != 5'd0) regs_q[rd] <= rd_val;
    end
  end

`ifdef RISCV_IC_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'h0;
      mtvec_q        <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
    end else if (!I_jtag_haltreq) begin
      if (irq_take) begin
        mepc_q         <= pc_q;
        mcause_q       <= 32'h8000_0000 | 32'(irq_idx);
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (ecall) begin
        mepc_q   <= pc_q;
        mcause_q <= 32'd11;
      end else if (mret) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          12'h300: begin
            mstatus_mie_q  <= csr_wdata[3];
            mstatus_mpie_q <= csr_wdata[7];
          end
          12'h304: mie_q    <= csr_wdata;
          12'h305: mtvec_q  <= csr_wdata;
          12'h341: mepc_q   <= csr_wdata;
          12'h342: mcause_q <= csr_wdata;
          default: ;
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_ic_core.sv
module tb_riscv_ic_core;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        O_ibus_req, O_ibus_we, O_dbus_req, O_dbus_we;
  logic [31:0] O_ibus_addr, O_ibus_data, O_dbus_addr, O_dbus_data;
  logic [3:0]  O_ibus_mask, O_dbus_mask;
  logic [31:0] I_ibus_data, I_dbus_data;
  logic [7:0]  I_int;
  logic        I_jtag_haltreq;

  int checks = 0;
  int errors = 0;
  logic [31:0] pc;

  always #5 clk = ~clk;

  riscv_ic_core dut (
    .clk(clk), .rst(rst),
    .O_ibus_req(O_ibus_req), .O_ibus_we(O_ibus_we), .O_ibus_addr(O_ibus_addr),
    .O_ibus_data(O_ibus_data), .O_ibus_mask(O_ibus_mask), .I_ibus_data(I_ibus_data),
    .O_dbus_req(O_dbus_req), .O_dbus_we(O_dbus_we), .O_dbus_addr(O_dbus_addr),
    .O_dbus_data(O_dbus_data), .O_dbus_mask(O_dbus_mask), .I_dbus_data(I_dbus_data),
    .I_int(I_int), .I_jtag_haltreq(I_jtag_haltreq)
  );

  // Instruction encoders
  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    logic [31:0] v = imm;
    return {v[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [31:0] v = imm;
    return {v[11:5], rs2, rs1, f3, v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [31:0] v = imm;
    return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  // Present one instruction for the coming rising edge; outputs are settled on return.
  task automatic issue(input logic [31:0] ins);
    @(negedge clk);
    I_ibus_data = ins;
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (O_ibus_req !== 1'b0) begin errors++;
      $display("FAIL rst_ibus_req got %b want 0", O_ibus_req); end
    checks++; if (O_dbus_req !== 1'b0) begin errors++;
      $display("FAIL rst_dbus_req got %b want 0", O_dbus_req); end
    @(negedge clk);
    rst = 1'b0;
    I_ibus_data = NOP;
    #1;
    checks++; if (O_ibus_addr !== 32'h8000_0000 || O_ibus_req !== 1'b1) begin errors++;
      $display("FAIL first_fetch got %h/%b want 80000000/1", O_ibus_addr, O_ibus_req); end
    issue(NOP);
    checks++; if (O_ibus_addr !== 32'h8000_0004) begin errors++;
      $display("FAIL second_fetch got %h want 80000004", O_ibus_addr); end
    pc = 32'h8000_0008;
  endtask

  task automatic test_alu;
    issue(enc_i(-1, 0, 3'd0, 1, 7'h13));
    checks++; if (O_dbus_req !== 1'b0 || O_dbus_mask !== 4'h0) begin errors++;
      $display("FAIL alu_no_dbus got %b/%h want 0/0", O_dbus_req, O_dbus_mask); end
    issue(enc_i(28, 1, 3'd5, 2, 7'h13));        // srli x2,x1,28
    issue(enc_i('h404, 1, 3'd5, 3, 7'h13));     // srai x3,x1,4
    issue(enc_s(0, 2, 0, 3'd2));                // sw x2,0(x0)
    checks++; if (O_dbus_data !== 32'h0000_000F) begin errors++;
      $display("FAIL srli got %h want 0000000f", O_dbus_data); end
    checks++; if ({O_dbus_req, O_dbus_we, O_dbus_mask} !== 6'b11_1111 ||
                  O_dbus_addr !== 32'h0) begin errors++;
      $display("FAIL sw_ctrl got %b%b%h %h want 11f 0", O_dbus_req, O_dbus_we, O_dbus_mask,
               O_dbus_addr); end
    issue(enc_s(4, 3, 0, 3'd2));
    checks++; if (O_dbus_data !== 32'hFFFF_FFFF || O_dbus_addr !== 32'h4) begin errors++;
      $display("FAIL srai got %h@%h want ffffffff@4", O_dbus_data, O_dbus_addr); end
    issue(enc_r(7'h20, 3, 2, 3'd0, 4));         // sub x4,x2,x3
    issue(enc_s(8, 4, 0, 3'd2));
    checks++; if (O_dbus_data !== 32'h0000_0010) begin errors++;
      $display("FAIL sub got %h want 00000010", O_dbus_data); end
    issue(enc_i(5, 0, 3'd0, 0, 7'h13));         // addi x0,x0,5
    issue(enc_s(0, 0, 0, 3'd2));
    checks++; if (O_dbus_data !== 32'h0) begin errors++;
      $display("FAIL x0_write got %h want 0", O_dbus_data); end
    pc = pc + 32'd36;
    issue(enc_b(8, 0, 0, 3'd0));                // beq taken
    checks++; if (O_ibus_addr !== pc) begin errors++;
      $display("FAIL beq_pc got %h want %h", O_ibus_addr, pc); end
    pc = pc + 32'd8;
    issue(enc_b(8, 0, 0, 3'd1));                // bne not taken
    checks++; if (O_ibus_addr !== pc) begin errors++;
      $display("FAIL beq_skip got %h want %h", O_ibus_addr, pc); end
    pc = pc + 32'd4;
    issue(enc_b(8, 2, 3, 3'd4));                // blt -1 < 15 taken
    checks++; if (O_ibus_addr !== pc) begin errors++;
      $display("FAIL bne_fall got %h want %h", O_ibus_addr, pc); end
    pc = pc + 32'd8;
    issue(enc_b(8, 2, 3, 3'd6));                // bltu 0xffffffff < 15 not taken
    checks++; if (O_ibus_addr !== pc) begin errors++;
      $display("FAIL blt_pc got %h want %h", O_ibus_addr, pc); end
    pc = pc + 32'd4;
    issue(NOP);
    checks++; if (O_ibus_addr !== pc) begin errors++;
      $display("FAIL bltu_pc got %h want %h", O_ibus_addr, pc); end
    pc = pc + 32'd4;
  endtask

  task automatic test_store;
    issue(enc_u(20'h80001, 5, 7'h37));
    issue(enc_i(3, 5, 3'd0, 5, 7'h13));
    issue(enc_u(20'h12345, 6, 7'h37));
    issue(enc_i('h678, 6, 3'd0, 6, 7'h13));
    issue(enc_s(0, 6, 5, 3'd0));                // sb
    checks++; if (O_dbus_addr !== 32'h8000_1000 || O_dbus_mask !== 4'b1000 ||
                  O_dbus_data !== 32'h7878_7878 || O_dbus_we !== 1'b1) begin errors++;
      $display("FAIL sb got %h %b %h %b want 80001000 1000 78787878 1", O_dbus_addr,
               O_dbus_mask, O_dbus_data, O_dbus_we); end
    issue(enc_s(0, 6, 5, 3'd1));                // sh
    checks++; if (O_dbus_mask !== 4'b1100 || O_dbus_data !== 32'h5678_5678) begin errors++;
      $display("FAIL sh got %b %h want 1100 56785678", O_dbus_mask, O_dbus_data); end
    issue(enc_s(-3, 6, 5, 3'd0));               // sb at 0x80001000
    checks++; if (O_dbus_mask !== 4'b0001) begin errors++;
      $display("FAIL sb_lane0 got %b want 0001", O_dbus_mask); end
    pc = pc + 32'd28;
  endtask

  task automatic test_load;
    I_dbus_data = 32'h80FF_7F01;
    issue(enc_u(20'h80001, 7, 7'h37));
    issue(enc_i(1, 7, 3'd0, 8, 7'h03));         // lb
    checks++; if (O_dbus_req !== 1'b1 || O_dbus_we !== 1'b0 ||
                  O_dbus_addr !== 32'h8000_1000) begin errors++;
      $display("FAIL lb_ctrl got %b %b %h want 1 0 80001000", O_dbus_req, O_dbus_we,
               O_dbus_addr); end
    issue(enc_i(2, 7, 3'd1, 9, 7'h03));         // lh
    issue(enc_i(3, 7, 3'd4, 10, 7'h03));        // lbu
    issue(enc_i(0, 7, 3'd5, 16, 7'h03));        // lhu
    issue(enc_i(3, 7, 3'd0, 17, 7'h03));        // lb sign
    issue(enc_s(0, 8, 0, 3'd2));
    checks++; if (O_dbus_data !== 32'h0000_007F) begin errors++;
      $display("FAIL lb got %h want 0000007f", O_dbus_data); end
    issue(enc_s(0, 9, 0, 3'd2));
    checks++; if (O_dbus_data !== 32'hFFFF_80FF) begin errors++;
      $display("FAIL lh got %h want ffff80ff", O_dbus_data); end
    issue(enc_s(0, 10, 0, 3'd2));
    checks++; if (O_dbus_data !== 32'h0000_0080) begin errors++;
      $display("FAIL lbu got %h want 00000080", O_dbus_data); end
    issue(enc_s(0, 16, 0, 3'd2));
    checks++; if (O_dbus_data !== 32'h0000_7F01) begin errors++;
      $display("FAIL lhu got %h want 00007f01", O_dbus_data); end
    issue(enc_s(0, 17, 0, 3'd2));
    checks++; if (O_dbus_data !== 32'hFFFF_FF80) begin errors++;
      $display("FAIL lb_neg got %h want ffffff80", O_dbus_data); end
    pc = pc + 32'd44;
  endtask

  task automatic test_jump;
    logic [31:0] link;
    issue(enc_j(16, 12));                       // jal x12,+16
    link = pc + 32'd4;
    pc = pc + 32'd16;
    issue(enc_s(0, 12, 0, 3'd2));
    checks++; if (O_ibus_addr !== pc || O_dbus_data !== link) begin errors++;
      $display("FAIL jal got %h/%h want %h/%h", O_ibus_addr, O_dbus_data, pc, link); end
    issue(enc_i(1, 12, 3'd0, 13, 7'h67));       // jalr x13,1(x12)
    pc = link;
    issue(32'hFFFF_FFFF);                       // unknown opcode
    checks++; if (O_ibus_addr !== pc || O_dbus_req !== 1'b0) begin errors++;
      $display("FAIL jalr got %h/%b want %h/0", O_ibus_addr, O_dbus_req, pc); end
    pc = pc + 32'd4;
    issue(enc_u(20'h00001, 14, 7'h17));         // auipc x14,1
    checks++; if (O_ibus_addr !== pc) begin errors++;
      $display("FAIL illegal_nop got %h want %h", O_ibus_addr, pc); end
    link = pc + 32'h1000;
    pc = pc + 32'd4;
    issue(enc_s(0, 14, 0, 3'd2));
    checks++; if (O_dbus_data !== link) begin errors++;
      $display("FAIL auipc got %h want %h", O_dbus_data, link); end
    pc = pc + 32'd4;
  endtask

  task automatic test_halt;
    issue(enc_i(5, 0, 3'd0, 11, 7'h13));
    pc = pc + 32'd4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      I_jtag_haltreq = 1'b1;
      I_ibus_data = (k == 0) ? enc_i(99, 0, 3'd0, 11, 7'h13) : enc_s(0, 6, 0, 3'd2);
      #1;
      checks++; if (O_ibus_addr !== pc || O_ibus_req !== 1'b0 || O_dbus_req !== 1'b0) begin
        errors++;
        $display("FAIL halt%0d got %h %b %b want %h 0 0", k, O_ibus_addr, O_ibus_req,
                 O_dbus_req, pc); end
    end
    @(negedge clk);
    I_jtag_haltreq = 1'b0;
    I_ibus_data = enc_s(0, 11, 0, 3'd2);
    #1;
    checks++; if (O_ibus_addr !== pc || O_dbus_data !== 32'd5 || O_ibus_req !== 1'b1) begin
      errors++;
      $display("FAIL halt_resume got %h %h want %h 00000005", O_ibus_addr, O_dbus_data, pc);
    end
    pc = pc + 32'd4;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    I_ibus_data = enc_s(0, 6, 0, 3'd2);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (O_ibus_addr !== 32'h8000_0000 || O_dbus_req !== 1'b0 ||
                  O_ibus_req !== 1'b0) begin errors++;
      $display("FAIL rst_async got %h %b %b want 80000000 0 0", O_ibus_addr, O_dbus_req,
               O_ibus_req); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (O_ibus_addr !== 32'h8000_0000 || O_dbus_data !== 32'h0) begin errors++;
      $display("FAIL rst_clear got %h %h want 80000000 0", O_ibus_addr, O_dbus_data); end
    pc = 32'h8000_0004;
  endtask

`ifdef RISCV_IC_IRQ_EN
  task automatic test_irq;
    logic [31:0] saved;
    issue(enc_u(20'h80000, 14, 7'h37));
    issue(enc_i('h100, 14, 3'd0, 14, 7'h13));
    issue(enc_i('h305, 14, 3'd1, 0, 7'h73));    // csrrw mtvec
    issue(enc_i('h304, 1, 3'd6, 0, 7'h73));     // csrrsi mie,1
    issue(enc_i('h300, 8, 3'd6, 0, 7'h73));     // csrrsi mstatus,8
    pc = pc + 32'd20;
    @(negedge clk);
    I_int = 8'h01;
    I_ibus_data = enc_i(1, 0, 3'd0, 20, 7'h13);
    #1;
    saved = pc;
    issue(enc_i('h342, 0, 3'd2, 15, 7'h73));    // csrr x15,mcause
    I_int = 8'h00;
    checks++; if (O_ibus_addr !== 32'h8000_0100) begin errors++;
      $display("FAIL irq_vec got %h want 80000100", O_ibus_addr); end
    issue(enc_s(0, 15, 0, 3'd2));
    checks++; if (O_dbus_data !== 32'h8000_0000) begin errors++;
      $display("FAIL irq_mcause got %h want 80000000", O_dbus_data); end
    issue(32'h3020_0073);                       // mret
    issue(NOP);
    checks++; if (O_ibus_addr !== saved) begin errors++;
      $display("FAIL mret got %h want %h", O_ibus_addr, saved); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    I_ibus_data = NOP;
    I_dbus_data = 32'h0;
    I_int = 8'h00;
    I_jtag_haltreq = 1'b0;
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_jump();
    test_halt();
    test_reset_mid();
`ifdef RISCV_IC_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
